// File: rtl/serial_restorer.sv
// Bit-serial adder that restores the minuend from a difference and its subtrahend.
// One full-adder cell plus a carry flop, LSB first, with a start/busy/done handshake.
module serial_restorer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] diff_in,
  input  logic [WIDTH-1:0] sub_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] a, a_d, b, b_d, p, p_d, sum_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             c, c_d, carry_d;
  logic             s_bit, c_next;

  // Next-state and datapath update; sum/carry only move on the final bit
  always_comb begin
    state_d = state;
    a_d     = a;
    b_d     = b;
    p_d     = p;
    cnt_d   = cnt;
    c_d     = c;
    sum_d   = sum;
    carry_d = carry;
    s_bit   = a[0] ^ b[0] ^ c;
    c_next  = (a[0] & b[0]) | (c & (a[0] ^ b[0]));
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          a_d     = diff_in;
          b_d     = sub_in;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a >> 1;
        b_d   = b >> 1;
        p_d   = (p >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
        c_d   = c_next;
        cnt_d = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          sum_d   = p_d;
          carry_d = c_next;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Busy/done registered from the next state so they line up with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      p     <= '0;
      cnt   <= '0;
      c     <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      a     <= a_d;
      b     <= b_d;
      p     <= p_d;
      cnt   <= cnt_d;
      c     <= c_d;
      sum   <= sum_d;
      carry <= carry_d;
      busy  <= (state_d == RUN);
      done  <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_serial_restorer.sv
// Self-checking bench for serial_restorer: directed table, random ops against an
// arithmetic reference, multi-cycle corner sequences, and an exhaustive WIDTH=1 instance.
module tb_serial_restorer;

  logic       clk;
  logic       rst;
  logic       start8, start1;
  logic [7:0] diff8, sub8, sum8;
  logic [0:0] diff1, sub1, sum1;
  logic       busy8, done8, carry8;
  logic       busy1, done1, carry1;

  int errors;
  int checks;

  logic [7:0] exp_sum_q;
  logic       exp_carry_q;
  logic [0:0] exp_sum1_q;
  logic       exp_carry1_q;

  serial_restorer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .diff_in(diff8), .sub_in(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
  );

  serial_restorer #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .diff_in(diff1), .sub_in(sub1),
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [7:0] s;
    logic [7:0] es;
    logic       ec;
    int         glitch;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Full WIDTH=8 operation: busy for 8 cycles, one done pulse, then 10 cycles of hold
  task automatic run8(input logic [7:0] d, input logic [7:0] s,
                      input logic [7:0] es, input logic ec, input int glitch);
    @(negedge clk);
    start8 = 1'b1;
    diff8  = d;
    sub8   = s;
    @(posedge clk);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      start8 = (i == glitch);
      diff8  = (i == glitch) ? 8'h7F : 8'($urandom);
      sub8   = (i == glitch) ? 8'h7F : 8'($urandom);
      chk("run8_busy_hold", {22'd0, busy8, done8, carry8, sum8},
          {22'd0, 1'b1, 1'b0, exp_carry_q, exp_sum_q});
      @(posedge clk);
    end
    @(negedge clk);
    start8 = 1'b0;
    chk("run8_done", {22'd0, busy8, done8, carry8, sum8}, {22'd0, 1'b0, 1'b1, ec, es});
    exp_sum_q   = es;
    exp_carry_q = ec;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("run8_after", {22'd0, busy8, done8, carry8, sum8},
          {22'd0, 1'b0, 1'b0, exp_carry_q, exp_sum_q});
    end
  endtask

  // WIDTH=1: minuend/subtrahend pair fed through the half-subtractor difference
  task automatic run1(input logic m, input logic s);
    logic [1:0] tot;
    tot = {1'b0, m ^ s} + {1'b0, s};
    @(negedge clk);
    start1 = 1'b1;
    diff1  = m ^ s;
    sub1   = s;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    chk("run1_busy", {28'd0, busy1, done1, carry1, sum1},
        {28'd0, 1'b1, 1'b0, exp_carry1_q, exp_sum1_q});
    @(negedge clk);
    chk("run1_done", {28'd0, busy1, done1, carry1, sum1}, {28'd0, 1'b0, 1'b1, tot[1], m});
    exp_sum1_q   = m;
    exp_carry1_q = tot[1];
    @(negedge clk);
    chk("run1_after", {29'd0, busy1, done1, sum1}, {29'd0, 1'b0, 1'b0, m});
  endtask

  initial begin
    vec_t vecs[4];
    int   n;
    logic [8:0] tot;
    logic [7:0] rd, rs;

    errors = 0;
    checks = 0;
    vecs[0] = '{d: 8'h05, s: 8'h03, es: 8'h08, ec: 1'b0, glitch: -1};
    vecs[1] = '{d: 8'hFF, s: 8'h01, es: 8'h00, ec: 1'b1, glitch: -1};
    vecs[2] = '{d: 8'hFE, s: 8'h03, es: 8'h01, ec: 1'b1, glitch: -1};
    vecs[3] = '{d: 8'h10, s: 8'h20, es: 8'h30, ec: 1'b0, glitch: 3};

    rst = 1'b1;
    start8 = 1'b0; diff8 = '0; sub8 = '0;
    start1 = 1'b0; diff1 = '0; sub1 = '0;
    exp_sum_q = '0; exp_carry_q = 1'b0;
    exp_sum1_q = '0; exp_carry1_q = 1'b0;
    #12;
    chk("reset_outputs", {20'd0, busy8, done8, carry8, sum8},
        {20'd0, 1'b0, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++)
      run8(vecs[i].d, vecs[i].s, vecs[i].es, vecs[i].ec, vecs[i].glitch);

    // Random operands against plain 9-bit addition
    for (int k = 0; k < 20; k++) begin
      rd  = 8'($urandom);
      rs  = 8'($urandom);
      tot = {1'b0, rd} + {1'b0, rs};
      run8(rd, rs, tot[7:0], tot[8], -1);
    end

    // Back-to-back: start held in the DONE cycle with a new pair
    @(negedge clk);
    start8 = 1'b1; diff8 = 8'h21; sub8 = 8'h42;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      start8 = 1'b0;
      n++;
    end while (!done8 && n < 30);
    chk("b2b_first_latency", 32'(n), 32'd9);
    chk("b2b_first_sum", {23'd0, carry8, sum8}, {23'd0, 1'b0, 8'h63});
    start8 = 1'b1; diff8 = 8'hC0; sub8 = 8'h50;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      start8 = 1'b0;
      n++;
    end while (!done8 && n < 30);
    chk("b2b_second_gap", 32'(n), 32'd9);
    chk("b2b_second_sum", {23'd0, carry8, sum8}, {23'd0, 1'b1, 8'h10});

    // Reset asserted between edges on the fourth RUN cycle
    @(negedge clk);
    start8 = 1'b1; diff8 = 8'h44; sub8 = 8'h11;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    chk("pre_abort_busy", {31'd0, busy8}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("reset_midrun_immediate", {20'd0, busy8, done8, carry8, sum8},
        {20'd0, 1'b0, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    rst = 1'b0;
    exp_sum_q = '0; exp_carry_q = 1'b0;
    exp_sum1_q = '0; exp_carry1_q = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 || busy8 || carry8 || (sum8 != 8'h00)) n++;
    end
    chk("abort_no_done", 32'(n), 32'd0);

    // WIDTH=1 exhaustive inverse of the half subtractor
    run1(1'b0, 1'b0);
    run1(1'b0, 1'b1);
    run1(1'b1, 1'b0);
    run1(1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_restorer.md
# serial_restorer

Bit-serial adder that performs the inverse of the half-subtractor stage. Given a difference word and the subtrahend word that produced it, it reconstructs the minuend: `sum = diff_in + sub_in`. It processes one bit per clock, LSB first, using a single full-adder cell and a carry flip-flop. It sits after the subtractor path as a check/restore stage and is driven through a start/busy/done handshake.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 1..32.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request; sampled on `clk` only in IDLE or DONE
- `diff_in`  in  WIDTH  difference operand; captured on the accepting edge
- `sub_in`  in  WIDTH  subtrahend operand; captured on the accepting edge
- `busy`  out  1  high while in RUN
- `done`  out  1  one-cycle pulse marking a valid result
- `sum`  out  WIDTH  reconstructed minuend, `(diff_in + sub_in) mod 2^WIDTH`
- `carry`  out  1  carry out of bit WIDTH-1

## Operation
- **States:** IDLE, RUN, DONE. Encoding is free.
- **Reset values** (asynchronous, immediate): state=IDLE, busy=0, done=0, sum=0, carry=0. Internal shift registers, bit counter and carry flip-flop are all 0.
- **IDLE or DONE with start=1:**
  - Load shift register A←`diff_in` and B←`sub_in`.
  - Clear the carry flip-flop and the bit counter.
  - Go to RUN.
- **IDLE with start=0:** stay in IDLE.
- **DONE with start=0:** go to IDLE.
- **RUN, each edge:**
  - Compute s = A[0]^B[0]^c and c' = (A[0]&B[0]) | (c&(A[0]^B[0])).
  - Shift A and B right by one.
  - Shift s into the MSB of the partial-result register.
  - Update the carry flip-flop to c' and increment the counter.
- **RUN, edge processing bit WIDTH-1:**
  - Copy the complete partial result to `sum` and c' to `carry`.
  - Go to DONE.
- **`start` during RUN:** ignored. The operands are not re-captured and the running operation is unaffected.
- **Output hold:** `sum` and `carry` change only on entry to DONE or on reset. They hold through IDLE and through any later RUN until that run completes.
- **Operand stability:** `diff_in` and `sub_in` are don't-care except on the accepting edge.
- **Arithmetic:**
  - Unsigned, modulo 2^WIDTH.
  - `carry` is the true 2^WIDTH bit.
  - In two's-complement terms, `sum` equals the original minuend whenever the subtractor's borrow chain produced `diff_in`.
- **Reset mid-RUN:** abort immediately to the reset values. No done pulse is issued for the aborted operation.

## Timing
- Let edge 0 be the edge on which start is accepted.
- `busy` = 1 from after edge 0 to after edge WIDTH.
- The bits are processed on edges 1..WIDTH.
- `done` = 1 and `sum`/`carry` are valid immediately after edge WIDTH, and `busy` = 0 in that same cycle.
- `done` drops after edge WIDTH+1.
- **Latency:** WIDTH+1 cycles from the accepting edge to the done cycle. `done` is never high for more than one cycle per operation.
- **Back-to-back:**
  - start=1 in the DONE cycle is accepted on edge WIDTH+1.
  - The next operation then completes on edge 2·WIDTH+1.
  - Sustained throughput is one result per WIDTH+1 cycles.
- `busy` and `done` are never high together.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset:**
  - Assert `rst` asynchronously, between clock edges.
  - Required: `sum`=0, `carry`=0, `busy`=0, `done`=0 immediately, without waiting for a clock edge.
- **Basic add (WIDTH=8):**
  - Stimulus: `diff_in`=8'h05, `sub_in`=8'h03, start pulsed once.
  - Required: `busy` high for 8 cycles; then `done` pulse with `sum`=8'h08, `carry`=0.
  - Required: `sum` still 8'h08 ten cycles later.
- **Wrap-around (WIDTH=8):**
  - Stimulus: `diff_in`=8'hFF, `sub_in`=8'h01.
  - Required: `sum`=8'h00, `carry`=1.
  - Stimulus: `diff_in`=8'hFE, `sub_in`=8'h03.
  - Required: `sum`=8'h01, `carry`=1.
- **Start ignored while busy:**
  - Stimulus: start with 8'h10+8'h20, then pulse start with 8'h7F+8'h7F on the third RUN cycle.
  - Required: exactly one `done`, after WIDTH+1 cycles, with `sum`=8'h30, `carry`=0.
- **Back-to-back and reset mid-run:**
  - Stimulus: hold start high through DONE with a new operand pair.
  - Required: the second result arrives 9 cycles after the first done.
  - Stimulus: assert `rst` on the fourth RUN cycle.
  - Required: no done pulse for the aborted operation; all outputs read 0.
- **WIDTH=1, exhaustive inverse of the half subtractor:**
  - Stimulus: the four (minuend, subtrahend) pairs, (0,0), (0,1), (1,0), (1,1), converted to `diff_in` = minuend^subtrahend.
  - Required: for each pair, `sum` equals the original minuend.
  - Required: `carry`=1 only for `diff_in`=1, `sub_in`=1, i.e. the (0,1) pair.
  - Required: `done` exactly 2 cycles after each accepting edge.
